random_col_picker: RTL and testbench
====================================

# random_col_picker

Parametrised random-column picker for the Connect-Four style game datapath. It replaces the fixed 6x7 random column generator used for the "place token randomly" (timeout) move. It fixes the board geometry only through parameters, adds a column-eligibility mask and a loadable seed, and guarantees termination with an explicit board-full indication. The search is a bounded sequential probe over a board snapshot with a request/valid handshake toward the game controller FSM.

## Interface
Parameters:
- ROWS, 6, board rows (≥1)
- COLS, 7, board columns (2..16)
- LFSR_W, 16, LFSR width (≥ clog2(COLS)+1)
- LFSR_TAPS, 16'hB400, Fibonacci feedback mask (bit i set = tap on lfsr[i])
- LFSR_SEED, 16'hACE1, reset value of LFSR (must be nonzero)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- req  in  1  start a pick; sampled only in IDLE
- board_state  in  2*ROWS*COLS  cell (r,c) at bits [2*(r*COLS+c) +: 2]; row 0 is top row; 2'b00 = empty
- col_mask  in  COLS  bit c = column c eligible
- seed_load  in  1  load seed into LFSR this edge
- seed  in  LFSR_W  seed value
- busy  out  1  search in progress
- col_out  out  clog2(COLS)  chosen column, held until next success
- col_valid  out  1  one-cycle pulse: col_out is fresh
- board_full  out  1  one-cycle pulse: no eligible non-full column

## Operation
- LFSR is free-running: each edge, lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}. Human timing of req supplies entropy.
- seed_load has priority over stepping at any time, including while busy. It loads seed, or LFSR_SEED if seed == 0. It never affects an in-flight search.
- States:
  - IDLE: if req, latch board_state and col_mask into snapshot registers, set cand = lfsr mod COLS (full-width unsigned modulo of the pre-edge lfsr value), probes = 0, and go to PROBE.
  - PROBE: a column is hit if col_mask_snap[cand] == 1 and snapshot top cell (row 0, column cand) == 2'b00.
    - On a hit: col_out <= cand, pulse col_valid, go to IDLE.
    - Else, if probes == COLS-1: pulse board_full, go to IDLE.
    - Else: cand <= (cand == COLS-1) ? 0 : cand+1 (wrap), probes++.
- The snapshot isolates the search from board_state changes during busy.
- req while busy is ignored and not queued.
- col_valid and board_full are never asserted together.
- A same-edge req with seed_load in IDLE: cand uses the pre-load lfsr, and the seed is loaded.

## Timing
- Reset values:
  - state = IDLE, lfsr = LFSR_SEED
  - busy = 0, col_out = 0, col_valid = 0, board_full = 0
  - cand, probes, and snapshots = 0
- Reset at any edge, including mid-search, aborts with no pulse.
- req sampled at edge 0. busy is high from after edge 0 until after the completing edge, and low in the cycle the pulse is visible.
- Probe p (p = 0..COLS-1) is evaluated at edge 1+p.
- Success at probe p: col_valid is high for the single cycle after edge 1+p. Latency is 1..COLS cycles.
- All columns ineligible or full: board_full is high for the single cycle after edge COLS.
- The earliest accepted back-to-back req is in the cycle the pulse is visible (state is IDLE then).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset mid-PROBE (rst high 1 cycle at edge 2 of a search) -> next cycle: busy=0, col_valid=0, board_full=0, col_out=0, lfsr=16'hACE1.
- seed_load seed=16'd3, next cycle req, empty board, mask=7'h7F -> cand=3; col_valid after 1 edge, col_out=3, busy high exactly 1 cycle.
- seed=16'd13, column 6 top occupied (bits[13:12]=2'b01), column 0 empty -> wrap; col_out=0, col_valid after edge 2.
- seed=16'd2, columns 2..5 full, mask bit 6 = 0 -> probes 2,3,4,5,6 fail; col_out=0 with col_valid after edge 6.
- All seven top cells nonzero (or mask=0) -> board_full pulse after edge 7, col_valid never asserted, col_out unchanged from its previous value.
- req held high through a search, and board_state changed after edge 0 -> exactly one result per search, computed from the snapshot; a second search starts the cycle the pulse is visible. seed_load seed=0 -> lfsr=16'hACE1.

Source files
------------

// File: rtl/random_col_picker_if.sv
// rtl/random_col_picker_if.sv - request/result bundle between game controller and random column picker
interface random_col_picker_if #(
  parameter int ROWS   = 6,
  parameter int COLS   = 7,
  parameter int LFSR_W = 16
);
  localparam int CW = $clog2(COLS);

  logic                     req;
  logic [2*ROWS*COLS-1:0]   board_state;
  logic [COLS-1:0]          col_mask;
  logic                     seed_load;
  logic [LFSR_W-1:0]        seed;
  logic                     busy;
  logic [CW-1:0]            col_out;
  logic                     col_valid;
  logic                     board_full;

  modport master (
    output req, board_state, col_mask, seed_load, seed,
    input  busy, col_out, col_valid, board_full
  );

  modport slave (
    input  req, board_state, col_mask, seed_load, seed,
    output busy, col_out, col_valid, board_full
  );
endinterface

// File: rtl/random_col_picker.sv
// rtl/random_col_picker.sv - LFSR-seeded sequential probe for a random eligible non-full column
module random_col_picker #(
  parameter int               ROWS      = 6,
  parameter int               COLS      = 7,
  parameter int               LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  random_col_picker_if.slave bus
);
  localparam int CW = $clog2(COLS);

  typedef enum logic {IDLE = 1'b0, PROBE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  logic [CW-1:0]          cand_q, cand_d;
  logic [CW-1:0]          probes_q, probes_d;
  logic [COLS-1:0][1:0]   snap_top_q, snap_top_d;
  logic [COLS-1:0]        mask_snap_q, mask_snap_d;
  logic [CW-1:0]          col_out_q, col_out_d;
  logic                   col_valid_q, col_valid_d;
  logic                   board_full_q, board_full_d;
  logic                   busy_q, busy_d;
  logic                   hit;
  logic                   unused_lower_rows;

  // Only the top row decides whether a column can take another token.
  assign unused_lower_rows = ^bus.board_state;

  assign hit = mask_snap_q[cand_q] && (snap_top_q[cand_q] == 2'b00);

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    probes_d     = probes_q;
    snap_top_d   = snap_top_q;
    mask_snap_d  = mask_snap_q;
    col_out_d    = col_out_q;
    col_valid_d  = 1'b0;
    board_full_d = 1'b0;

    if (bus.seed_load) begin
      lfsr_d = (bus.seed == '0) ? LFSR_SEED : bus.seed;
    end else begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          snap_top_d  = bus.board_state[2*COLS-1:0];
          mask_snap_d = bus.col_mask;
          cand_d      = CW'(lfsr_q % LFSR_W'(COLS));
          probes_d    = '0;
          state_d     = PROBE;
        end
      end
      PROBE: begin
        if (hit) begin
          col_out_d   = cand_q;
          col_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (probes_q == CW'(COLS - 1)) begin
          board_full_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cand_d   = (cand_q == CW'(COLS - 1)) ? '0 : cand_q + 1'b1;
          probes_d = probes_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PROBE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      cand_q       <= '0;
      probes_q     <= '0;
      snap_top_q   <= '0;
      mask_snap_q  <= '0;
      col_out_q    <= '0;
      col_valid_q  <= 1'b0;
      board_full_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cand_q       <= cand_d;
      probes_q     <= probes_d;
      snap_top_q   <= snap_top_d;
      mask_snap_q  <= mask_snap_d;
      col_out_q    <= col_out_d;
      col_valid_q  <= col_valid_d;
      board_full_q <= board_full_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.col_out    = col_out_q;
  assign bus.col_valid  = col_valid_q;
  assign bus.board_full = board_full_q;
endmodule

// File: tb/tb_random_col_picker.sv
// tb/tb_random_col_picker.sv - randomized and directed checks of random_col_picker against a search model
module tb_random_col_picker;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int W    = 16;
  localparam int BW   = 2 * ROWS * COLS;
  localparam logic [W-1:0] SEED_RST = 16'hACE1;
  localparam logic [W-1:0] TAPS     = 16'hB400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  random_col_picker_if #(.ROWS(ROWS), .COLS(COLS), .LFSR_W(W)) bus ();

  random_col_picker #(.ROWS(ROWS), .COLS(COLS), .LFSR_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: on acceptance, decide the whole search outcome at once from the snapshot.
  logic [W-1:0] m_lfsr;
  bit           m_live = 0;
  bit           m_busy, m_valid, m_full, m_hit;
  int           m_rem, m_col, m_pcol;

  always @(posedge clk) begin
    logic [W-1:0] pre;
    int start, c;
    if (rst) begin
      m_lfsr = SEED_RST; m_busy = 0; m_valid = 0; m_full = 0;
      m_col = 0; m_rem = 0; m_live = 1;
    end else if (m_live) begin
      pre = m_lfsr;
      m_valid = 0; m_full = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          if (m_hit) begin m_valid = 1; m_col = m_pcol; end
          else m_full = 1;
        end
      end else if (bus.req) begin
        start = int'(pre) % COLS;
        m_hit = 0; m_rem = COLS;
        for (int p = 0; p < COLS; p++) begin
          c = (start + p) % COLS;
          if (!m_hit && bus.col_mask[c] && bus.board_state[2*c +: 2] == 2'b00) begin
            m_hit = 1; m_pcol = c; m_rem = p + 1;
          end
        end
        m_busy = 1;
      end
      if (bus.seed_load) m_lfsr = (bus.seed != 0) ? bus.seed : SEED_RST;
      else               m_lfsr = {pre[W-2:0], ^(pre & TAPS)};
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      chk("busy",       32'(bus.busy),       32'(m_busy));
      chk("col_valid",  32'(bus.col_valid),  32'(m_valid));
      chk("board_full", 32'(bus.board_full), 32'(m_full));
      chk("col_out",    32'(bus.col_out),    32'(m_col));
      chk("lfsr",       32'(dut.lfsr_q),     32'(m_lfsr));
    end
  end

  task automatic pick(input string nm, input logic [W-1:0] s, input logic [BW-1:0] b,
                      input logic [COLS-1:0] m, input int exp_lat, input bit exp_full,
                      input int exp_col);
    int n;
    bit got;
    @(negedge clk); bus.seed_load = 1; bus.seed = s; bus.board_state = b; bus.col_mask = m; bus.req = 0;
    @(negedge clk); bus.seed_load = 0; bus.req = 1;
    @(negedge clk); bus.req = 0;
    n = 1; got = 0;
    while (!got && n < 40) begin
      if (bus.col_valid || bus.board_full) got = 1;
      else begin @(negedge clk); n++; end
    end
    chk({nm, "_latency"}, got ? 32'(n - 1) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({nm, "_full"},    32'(bus.board_full), 32'(exp_full));
    chk({nm, "_valid"},   32'(bus.col_valid),  32'(!exp_full));
    chk({nm, "_col"},     32'(bus.col_out),    32'(exp_col));
  endtask

  function automatic logic [BW-1:0] rand_board();
    logic [BW-1:0] b = '0;
    for (int i = 0; i < ROWS * COLS; i++)
      if ($urandom % 5 < 2) b[2*i +: 2] = 2'($urandom_range(1, 3));
    return b;
  endfunction

  initial begin
    int pulses;
    bus.req = 0; bus.board_state = '0; bus.col_mask = '0; bus.seed_load = 0; bus.seed = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy",  32'(bus.busy),    32'd0);
    chk("rst_col",   32'(bus.col_out), 32'd0);
    chk("rst_lfsr",  32'(dut.lfsr_q),  32'hACE1);
    chk("rst_valid", 32'(bus.col_valid | bus.board_full), 32'd0);
    rst = 0;

    pick("seed3",    16'd3,  '0,                   7'h7F, 1, 0, 3);
    pick("all_full", 16'd5,  BW'(84'h1555),        7'h7F, 7, 1, 3);
    pick("mask0",    16'd9,  '0,                   7'h00, 7, 1, 3);

    // Abort a search in flight: rst sampled at edge 2.
    @(negedge clk); bus.board_state = BW'(84'h1555); bus.col_mask = 7'h7F; bus.req = 1;
    @(negedge clk); bus.req = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("abort_busy",  32'(bus.busy),       32'd0);
    chk("abort_valid", 32'(bus.col_valid),  32'd0);
    chk("abort_full",  32'(bus.board_full), 32'd0);
    chk("abort_col",   32'(bus.col_out),    32'd0);
    chk("abort_lfsr",  32'(dut.lfsr_q),     32'hACE1);

    pick("wrap",     16'd13, BW'(84'h1000),        7'h7F, 2, 0, 0);
    pick("skip",     16'd2,  BW'(84'h550),         7'h3F, 6, 0, 0);

    // req held high while the board changes under a running search.
    pulses = 0;
    @(negedge clk); bus.col_mask = 7'h7F; bus.req = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.board_state = rand_board();
      if (bus.col_valid || bus.board_full) pulses++;
    end
    bus.req = 0;
    chk("held_req_pulses", 32'(pulses >= 5), 32'd1);

    @(negedge clk); bus.seed_load = 1; bus.seed = '0;
    @(negedge clk); bus.seed_load = 0;
    chk("seed0_lfsr", 32'(dut.lfsr_q), 32'hACE1);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.req         = ($urandom % 3 == 0);
      bus.seed_load   = ($urandom % 16 == 0);
      bus.seed        = ($urandom % 4 == 0) ? '0 : W'($urandom);
      bus.col_mask    = ($urandom % 4 == 0) ? COLS'($urandom) : 7'h7F;
      bus.board_state = rand_board();
      rst             = ($urandom % 97 == 0);
    end
    @(negedge clk); rst = 0; bus.req = 0; bus.seed_load = 0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
